// File: rtl/mux_pkg.sv
// mux_pkg: shared mode/state types and channel limit for mux_seq.
package mux_pkg;
  typedef enum logic {MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1} mode_e;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;
  localparam int MUX_MAX_CH = 256;
endpackage

// File: rtl/mux_seq_next_ch.sv
// mux_seq_next_ch: lowest enabled channel at or above base; found=0 means none remain.
module mux_seq_next_ch #(
  parameter int N_IN = 16,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  mask,
  input  logic [SEL_W:0]   base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = N_IN - 1; k >= 0; k--)
      if (mask[k] && k >= int'(base)) begin
        found = 1'b1;
        idx = SEL_W'(k);
      end
  end
endmodule

// File: rtl/mux_seq.sv
// mux_seq: registered N:1 channel mux with valid/ready output stage and scan sequencer.
// Define MUX_SEQ_MASK_EN to add the ch_mask scan-enable port.
module mux_seq
  import mux_pkg::*;
#(
  parameter int N_IN = 16,
  parameter int W = 8,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN*W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              start,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err
`ifdef MUX_SEQ_MASK_EN
  ,
  input  logic [N_IN-1:0]   ch_mask
`endif
);
  state_e state, state_nx;
  logic [SEL_W-1:0] ptr, ptr_nx, idx, nxt;
  logic [SEL_W:0] base;
  logic [N_IN-1:0] mask;
  logic free, cap, go, found, in_rng, err_q, pulse_q;
`ifdef MUX_SEQ_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif
  assign free = !out_valid || out_ready;
  assign in_ready = rst_n && free && (state == SCAN || mode == MODE_MANUAL);
  assign cap = in_valid && in_ready;
  assign go = state == IDLE && start && mode == MODE_SCAN;
  assign idx = state == SCAN ? ptr : sel;
  assign in_rng = int'(idx) < N_IN;
  // IDLE searches from channel 0 for a new scan; SCAN searches past the current pointer
  assign base = state == SCAN ? {1'b0, ptr} + 1'b1 : '0;
  assign sel_err = err_q | pulse_q;

  mux_seq_next_ch #(.N_IN(N_IN)) u_next (.mask(mask), .base(base), .found(found), .idx(nxt));

  always_comb begin
    state_nx = (go && found) ? SCAN : (state == SCAN && cap && !found) ? IDLE : state;
    ptr_nx = ((go || (state == SCAN && cap)) && found) ? nxt : ptr;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      out_data <= '0;
      out_ch <= '0;
      out_last <= 1'b0;
      out_valid <= 1'b0;
      err_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      pulse_q <= go && !found;
      if (cap) begin
        out_data <= in_rng ? in_data[int'(idx)*W +: W] : '0;
        out_ch <= idx;
        err_q <= !in_rng;
        out_last <= state == SCAN && !found;
        out_valid <= 1'b1;
      end else if (out_ready)
        out_valid <= 1'b0;
    end
endmodule

// File: doc/mux_seq.md
# mux_seq

Parametrised, registered N-to-1 channel multiplexer with a valid/ready output stage and an auto-scan sequencer. It generalises the team's fixed 16:1 single-bit muxes to N_IN channels of W bits. It adds a manual-select mode and a scan mode that walks every channel once per start command. It sits between multi-channel sample sources and a single-lane consumer such as a serialiser or debug capture.

## Interface
- N_IN, 16, number of input channels (2..256)
- W, 8, bits per channel
- SEL_W, $clog2(N_IN), select/channel-index width (derived, not overridden)
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N_IN*W  packed channels; channel k = in_data[k*W +: W]
- in_valid  in  1  in_data holds a valid sample set this cycle
- in_ready  out  1  block accepts a sample set this cycle
- mode  in  1  0 = manual (use sel), 1 = scan
- sel  in  SEL_W  manual channel select
- start  in  1  single-cycle pulse; begins a scan when in IDLE and mode=1
- out_data  out  W  registered selected channel
- out_ch  out  SEL_W  channel index of out_data
- out_last  out  1  marks the final sample of a scan
- out_valid  out  1  out_data/out_ch/out_last valid
- out_ready  in  1  consumer accepts output
- sel_err  out  1  error flag, registered with the sample or pulsed (see Operation)
- ch_mask  in  N_IN  scan channel enable; present only with MUX_SEQ_MASK_EN

## Operation
- States: IDLE, SCAN. Internal scan pointer ptr (SEL_W bits).
- Output register is free when !out_valid || out_ready.
- in_ready = free && (state==SCAN || mode==0).
- A capture occurs on in_valid && in_ready:
  - IDLE, mode 0: index = sel.
  - SCAN: index = ptr.
- On capture, the output register loads:
  - out_data = channel[index]; if index >= N_IN, out_data = 0.
  - out_ch = index.
  - sel_err = (index >= N_IN).
  - out_valid = 1.
- If out_ready is high and there is no capture, out_valid drops to 0.
- IDLE→SCAN: start && mode==1. ptr loads the first enabled channel. start in SCAN, or with mode 0, is ignored.
- In SCAN, each capture advances ptr to the next enabled channel. The capture of the last enabled channel sets out_last=1, and state returns to IDLE in the same clock edge.
- mode changes during SCAN are ignored until the scan completes.
- Scan order is ascending index; channels >= N_IN are never scanned.
- All-disabled mask (macro on) with start in IDLE: stays IDLE, sel_err pulses one cycle, out_valid unaffected.

## Timing
- Reset: out_data=0, out_ch=0, out_last=0, out_valid=0, sel_err=0, in_ready=0 during reset, state=IDLE, ptr=0.
- Latency: capture at edge n, out_valid at n (registered, visible in cycle n+1 after in_valid).
- Throughput: one sample per cycle when out_ready is held high.
- Backpressure: with out_valid=1 and out_ready=0, all outputs hold stable and in_ready=0.
- start and a capture in the same IDLE cycle: start takes effect, and no manual capture occurs (in_ready=0 since mode=1).
- Reset mid-scan aborts immediately. The next scan restarts at the first enabled channel.

## Configuration
- MUX_SEQ_MASK_EN defined: ch_mask port exists; scan visits only channels with ch_mask[k]=1. ch_mask is sampled at start and at each ptr advance.
- MUX_SEQ_MASK_EN undefined: no ch_mask port; scan visits 0..N_IN-1 and the all-disabled case cannot occur.

## Structure
- Shared package mux_pkg holds:
  - mode_e (MODE_MANUAL=0, MODE_SCAN=1).
  - state_e (IDLE, SCAN).
  - Constant MUX_MAX_CH=256.
- One sub-module, mux_seq_next_ch: combinational find-next-enabled-channel above a given index, with a found/last flag. It is used for both the start and advance cases.

## Test plan
- N_IN=16, W=8; mode 0, sel=5, channel5=0xA5, in_valid=1, out_ready=1 → next cycle out_data=0xA5, out_ch=5, out_valid=1, sel_err=0.
- Same setup, out_ready=0 for 3 cycles with changing in_data → out_data held at 0xA5, in_ready=0; first sample after release reflects current in_data.
- mode 1, start pulse, in_valid and out_ready held high → out_ch 0..15 on 16 consecutive cycles, out_last only with ch 15, then IDLE and in_ready=0.
- MUX_SEQ_MASK_EN, ch_mask=0x0005 → scan outputs ch 0 then ch 2 (out_last=1). ch_mask=0 with start → sel_err one-cycle pulse, no output.
- N_IN=12, mode 0, sel=13 → out_data=0, out_ch=13, sel_err=1 with out_valid.
- Assert rst_n low while out_ch=7 mid-scan → all outputs 0, IDLE. After release, start → first output ch 0.
